// File: rtl/sb_frame_receiver.sv
// sb_frame_receiver
//   Receive-side sideband framer. Removes DLE stuffing from the SBRX byte
//   stream, delimits DLE-STX ... DLE-ETX frames, checks the trailing CRC-16
//   and holds the unstuffed bytes in a local buffer until the consumer acks.
//
// Ports
//   system_clk     single clock
//   rst_n          asynchronous active-low reset
//   sb_byte        received sideband byte
//   sb_byte_valid  sb_byte is valid this cycle (all framing state freezes otherwise)
//   frame_valid    complete frame held in buffer (level, until acked)
//   frame_type     0 = LT, 1 = AT
//   frame_len      payload length, CRC bytes excluded
//   crc_ok         received CRC matched the computed one
//   frame_ack      consumer releases the buffer
//   rd_addr        buffer read address
//   rd_data        buffer[rd_addr], registered (1-cycle latency)
//   abort          one-cycle pulse when a frame is discarded as malformed
//   drop_cnt       saturating count of frames dropped while the buffer was locked
module sb_frame_receiver #(
  parameter int unsigned MAX_LEN = 32,
  parameter logic [7:0]  DLE     = 8'hFE,
  parameter logic [7:0]  STX_LT  = 8'h05,
  parameter logic [7:0]  STX_AT  = 8'h04,
  parameter logic [7:0]  ETX     = 8'h40,
  parameter int unsigned LW      = $clog2(MAX_LEN + 1)
) (
  input  logic          system_clk,
  input  logic          rst_n,
  input  logic [7:0]    sb_byte,
  input  logic          sb_byte_valid,
  output logic          frame_valid,
  output logic          frame_type,
  output logic [LW-1:0] frame_len,
  output logic          crc_ok,
  input  logic          frame_ack,
  input  logic [LW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          abort,
  output logic [7:0]    drop_cnt
);

  // Payload plus the two CRC bytes land in the buffer.
  localparam int unsigned DEPTH = MAX_LEN + 2;
  localparam int unsigned CW    = $clog2(MAX_LEN + 4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_ESC
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [15:0]   crc, crc_nxt;
  logic [7:0]    sh0, sh0_nxt;       // older byte of the CRC delay line
  logic [7:0]    sh1, sh1_nxt;       // newer byte of the CRC delay line
  logic          discard, discard_nxt;
  logic          cur_type, cur_type_nxt;

  logic          wr_en;
  logic          commit;
  logic          abort_nxt;
  logic          drop_inc;
  logic          take;
  logic          start;
  logic          is_stx;
  logic          locked;

  logic [7:0]    mem [DEPTH];

  // MSB-first CRC-16, polynomial 0x8005, one byte per call.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      if (r[15]) r = (r << 1) ^ 16'h8005;
      else       r = r << 1;
    end
    return r;
  endfunction

  assign is_stx = (sb_byte == STX_LT) || (sb_byte == STX_AT);
  // An ack in the same cycle unlocks first, so a frame starting now is kept.
  assign locked = frame_valid && !frame_ack;

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      crc      <= '1;
      sh0      <= '0;
      sh1      <= '0;
      discard  <= 1'b0;
      cur_type <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      crc      <= crc_nxt;
      sh0      <= sh0_nxt;
      sh1      <= sh1_nxt;
      discard  <= discard_nxt;
      cur_type <= cur_type_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    crc_nxt      = crc;
    sh0_nxt      = sh0;
    sh1_nxt      = sh1;
    discard_nxt  = discard;
    cur_type_nxt = cur_type;
    wr_en        = 1'b0;
    commit       = 1'b0;
    abort_nxt    = 1'b0;
    drop_inc     = 1'b0;
    take         = 1'b0;
    start        = 1'b0;

    if (sb_byte_valid) begin
      case (state)
        ST_IDLE: begin
          if (sb_byte == DLE) state_nxt = ST_START;
        end
        ST_START: begin
          if (is_stx)               start     = 1'b1;
          else if (sb_byte != DLE)  state_nxt = ST_IDLE;
        end
        ST_DATA: begin
          if (sb_byte == DLE) state_nxt = ST_ESC;
          else                take      = 1'b1;
        end
        ST_ESC: begin
          if (sb_byte == DLE) begin
            take      = 1'b1;
            state_nxt = ST_DATA;
          end else if (sb_byte == ETX) begin
            state_nxt = ST_IDLE;
            if (cnt < CW'(2)) abort_nxt = 1'b1;
            else              commit    = !discard;
          end else if (is_stx) begin
            start = 1'b1;
          end else begin
            abort_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase

      if (start) begin
        state_nxt    = ST_DATA;
        cur_type_nxt = (sb_byte == STX_AT);
        cnt_nxt      = '0;
        crc_nxt      = crc_byte(16'hFFFF, sb_byte);
        discard_nxt  = locked;
        drop_inc     = locked;
      end

      // Bytes reach the CRC two positions late, so at ETX the delay line
      // holds exactly the received CRC and the accumulator excludes it.
      if (take) begin
        if (cnt == CW'(DEPTH)) begin
          abort_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wr_en   = !discard;
          cnt_nxt = cnt + 1'b1;
          if (cnt >= CW'(2)) crc_nxt = crc_byte(crc, sh0);
          sh0_nxt = sh1;
          sh1_nxt = sb_byte;
        end
      end
    end
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid <= 1'b0;
      frame_type  <= 1'b0;
      frame_len   <= '0;
      crc_ok      <= 1'b0;
      abort       <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      abort <= abort_nxt;
      if (frame_valid && frame_ack) frame_valid <= 1'b0;
      if (commit) begin
        frame_valid <= 1'b1;
        frame_type  <= cur_type;
        frame_len   <= LW'(cnt - CW'(2));
        crc_ok      <= (crc == {sh1, sh0});
      end
      if (drop_inc && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  always_ff @(posedge system_clk) begin
    if (wr_en) mem[cnt] <= sb_byte;
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (32'(rd_addr) < DEPTH) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_sb_frame_receiver.sv
module tb_sb_frame_receiver;

  localparam int DEPTH = 34;
  localparam logic [7:0] DLE = 8'hFE, STX_LT = 8'h05, STX_AT = 8'h04, ETX = 8'h40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sb_byte = '0;
  logic       sb_byte_valid = 1'b0;
  logic       frame_ack = 1'b0;
  logic [5:0] rd_addr = '0;
  logic       frame_valid, frame_type, crc_ok, abort;
  logic [5:0] frame_len;
  logic [7:0] rd_data, drop_cnt;

  int  vectors = 0;
  int  miscompares = 0;
  bit  rand_mode = 1'b0;

  sb_frame_receiver #(
    .MAX_LEN(32), .DLE(8'hFE), .STX_LT(8'h05), .STX_AT(8'h04), .ETX(8'h40), .LW(6)
  ) dut (
    .system_clk(clk), .rst_n(rst_n), .sb_byte(sb_byte), .sb_byte_valid(sb_byte_valid),
    .frame_valid(frame_valid), .frame_type(frame_type), .frame_len(frame_len),
    .crc_ok(crc_ok), .frame_ack(frame_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .abort(abort), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC as polynomial long division over the whole message, bit by bit.
  function automatic logic [15:0] crc_msg(input logic [7:0] msg[$]);
    logic [15:0] c = 16'hFFFF;
    bit fb;
    foreach (msg[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ msg[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    return c;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] mbuf [DEPTH];
  bit         mknown [DEPTH];
  bit         m_fv, m_type, m_crcok, m_abort, m_rd_known;
  logic [5:0] m_len;
  logic [7:0] m_drop, m_rd;
  bit         in_frame, esc, pend, disc;
  logic [7:0] stx;
  logic [7:0] q[$];

  task automatic m_add(input logic [7:0] b);
    if (q.size() == DEPTH) begin
      m_abort = 1'b1;
      in_frame = 1'b0;
    end else begin
      if (!disc) begin
        mbuf[q.size()] = b;
        mknown[q.size()] = 1'b1;
      end
      q.push_back(b);
    end
  endtask

  task automatic m_begin(input logic [7:0] b, input bit lk);
    in_frame = 1'b1; esc = 1'b0; pend = 1'b0;
    q.delete();
    stx = b;
    disc = lk;
    if (lk && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
  endtask

  task automatic m_finish();
    logic [7:0] msg[$];
    int n;
    in_frame = 1'b0;
    n = q.size();
    if (n < 2) m_abort = 1'b1;
    else if (!disc) begin
      msg.push_back(stx);
      for (int k = 0; k < n - 2; k++) msg.push_back(q[k]);
      m_fv = 1'b1;
      m_type = (stx == STX_AT);
      m_len = 6'(n - 2);
      m_crcok = (crc_msg(msg) == {q[n-1], q[n-2]});
    end
  endtask

  task automatic m_byte(input logic [7:0] b, input bit lk);
    if (!in_frame) begin
      if (pend && (b == STX_LT || b == STX_AT)) m_begin(b, lk);
      else pend = (b == DLE);
    end else if (!esc) begin
      if (b == DLE) esc = 1'b1;
      else m_add(b);
    end else begin
      esc = 1'b0;
      if (b == DLE) m_add(b);
      else if (b == ETX) m_finish();
      else if (b == STX_LT || b == STX_AT) m_begin(b, lk);
      else begin
        m_abort = 1'b1;
        in_frame = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit lk;
    if (!rst_n) begin
      m_fv = 0; m_type = 0; m_crcok = 0; m_abort = 0; m_len = '0; m_drop = '0;
      m_rd = '0; m_rd_known = 1'b1;
      in_frame = 0; esc = 0; pend = 0; disc = 0;
      q.delete();
      foreach (mknown[k]) mknown[k] = 1'b0;
    end else begin
      if (rd_addr >= DEPTH) begin
        m_rd = '0; m_rd_known = 1'b1;
      end else begin
        m_rd = mbuf[rd_addr]; m_rd_known = mknown[rd_addr];
      end
      lk = m_fv && !frame_ack;
      if (m_fv && frame_ack) m_fv = 1'b0;
      m_abort = 1'b0;
      if (sb_byte_valid) m_byte(sb_byte, lk);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("frame_valid", frame_valid, m_fv);
      check("frame_type", frame_type, m_type);
      check("frame_len", frame_len, m_len);
      check("crc_ok", crc_ok, m_crcok);
      check("abort", abort, m_abort);
      check("drop_cnt", drop_cnt, m_drop);
      if (m_rd_known) check("rd_data", rd_data, m_rd);
    end
  end

  always @(negedge clk) begin
    if (rand_mode) begin
      frame_ack = ($urandom_range(0, 9) == 0);
      rd_addr = 6'($urandom_range(0, 63));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    sb_byte = b;
    sb_byte_valid = 1'b1;
    @(negedge clk);
    sb_byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_stuffed(input logic [7:0] b, input bit gaps);
    if (b == DLE) send(DLE);
    send(b);
    if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] pl[$], input bit corrupt,
                            input bit ack_on_stx, input bit gaps);
    logic [7:0] msg[$];
    logic [15:0] c;
    msg = pl;
    msg.push_front(s);
    c = crc_msg(msg);
    send(DLE);
    if (ack_on_stx) frame_ack = 1'b1;
    send(s);
    frame_ack = 1'b0;
    foreach (pl[k]) send_stuffed(pl[k], gaps);
    send_stuffed(c[7:0] ^ {7'd0, corrupt}, gaps);
    send_stuffed(c[15:8], gaps);
    send(DLE);
    send(ETX);
  endtask

  task automatic read_check(input logic [5:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge clk);
    check("rd_literal", rd_data, exp);
  endtask

  task automatic do_ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  function automatic logic [7:0] rnd_byte();
    int r = $urandom_range(0, 9);
    case (r)
      0: return DLE;
      1: return STX_LT;
      2: return STX_AT;
      3: return ETX;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    logic [7:0] pl[$];
    int kind, len;

    idle(3);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_frame_len", frame_len, 0);
    #2 rst_n = 1'b1;
    idle(1);

    // LT frame 11 22 33
    pl = '{8'h11, 8'h22, 8'h33};
    send_frame(STX_LT, pl, 0, 0, 0);
    check("lt_valid", frame_valid, 1);
    check("lt_type", frame_type, 0);
    check("lt_len", frame_len, 3);
    check("lt_crc_ok", crc_ok, 1);
    read_check(0, 8'h11); read_check(1, 8'h22); read_check(2, 8'h33);
    do_ack();
    check("ack_clears", frame_valid, 0);

    // AT frame with stuffed FE
    pl = '{8'hFE, 8'hAA};
    send_frame(STX_AT, pl, 0, 0, 0);
    check("at_type", frame_type, 1);
    check("at_len", frame_len, 2);
    check("at_crc_ok", crc_ok, 1);
    read_check(0, 8'hFE); read_check(1, 8'hAA);
    do_ack();
    send_frame(STX_AT, pl, 1, 0, 0);
    check("bad_valid", frame_valid, 1);
    check("bad_crc_ok", crc_ok, 0);
    do_ack();

    // bad escape
    send(DLE); send(STX_LT); send(8'h11); send(DLE); send(8'h33);
    check("esc_abort", abort, 1);
    idle(1);
    check("esc_abort_pulse", abort, 0);
    pl = '{8'h01, 8'h02};
    send_frame(STX_LT, pl, 0, 0, 0);
    check("after_abort_crc", crc_ok, 1);
    check("after_abort_len", frame_len, 2);
    do_ack();

    // overflow: 35 unstuffed bytes
    send(DLE); send(STX_LT);
    for (int i = 0; i < 35; i++) send(8'($urandom_range(0, 253)));
    check("ovf_abort", abort, 1);
    check("ovf_valid", frame_valid, 0);
    idle(2);

    // lock, three dropped frames, then ack on STX
    pl = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_frame(STX_LT, pl, 0, 0, 0);
    for (int f = 0; f < 3; f++) begin
      pl = '{8'h55, 8'h66, 8'($urandom_range(0, 255))};
      send_frame(STX_AT, pl, 0, 0, 0);
    end
    check("lock_drop", drop_cnt, 3);
    check("lock_len", frame_len, 4);
    check("lock_type", frame_type, 0);
    read_check(0, 8'hA1); read_check(3, 8'hD4);
    pl = '{8'h77, 8'h88, 8'h99, 8'hFE, 8'h12};
    send_frame(STX_AT, pl, 0, 1, 0);
    check("ackstx_valid", frame_valid, 1);
    check("ackstx_type", frame_type, 1);
    check("ackstx_len", frame_len, 5);
    check("ackstx_drop", drop_cnt, 3);
    read_check(3, 8'hFE);

    // reset mid-payload while locked
    send(DLE); send(STX_LT); send(8'h31); send(8'h32);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", frame_valid, 0);
    check("arst_type", frame_type, 0);
    check("arst_len", frame_len, 0);
    check("arst_crc", crc_ok, 0);
    check("arst_drop", drop_cnt, 0);
    check("arst_rd", rd_data, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(1);
    pl = '{8'h9A, 8'hBC, 8'hDE};
    send_frame(STX_LT, pl, 0, 0, 0);
    check("post_rst_valid", frame_valid, 1);
    check("post_rst_crc", crc_ok, 1);
    check("post_rst_abort", abort, 0);
    do_ack();

    // randomized traffic
    rand_mode = 1'b1;
    for (int f = 0; f < 200; f++) begin
      kind = $urandom_range(0, 9);
      pl.delete();
      if (kind <= 5) begin
        len = $urandom_range(0, 32);
        for (int i = 0; i < len; i++) pl.push_back(($urandom_range(0, 3) == 0) ? DLE : 8'($urandom_range(0, 255)));
        send_frame(($urandom_range(0, 1) == 1) ? STX_AT : STX_LT, pl, ($urandom_range(0, 4) == 0), 0, 1);
      end else if (kind == 6) begin
        len = $urandom_range(31, 36);
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_frame(STX_LT, pl, 0, 0, 0);
      end else if (kind == 7) begin
        send(DLE); send(STX_AT);
        if ($urandom_range(0, 1) == 1) send(8'h21);
        send(DLE); send(ETX);
      end else begin
        len = $urandom_range(1, 8);
        for (int i = 0; i < len; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          send(rnd_byte());
        end
      end
      idle($urandom_range(0, 3));
    end
    rand_mode = 1'b0;
    @(negedge clk);
    frame_ack = 1'b0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
